nor_tree_pipe: RTL and testbench
================================

# nor_tree_pipe

Parametrised, pipelined wide-NOR reduction block for the standard-cell library. It is the sequential successor to the 3-input NOR cell: it takes `CHANNELS` independent `WIDTH`-bit input vectors and reduces each one through a registered tree of 3-input stages. Each channel produces a single NOR result. A valid/ready handshake with full backpressure wraps the pipeline. It sits wherever synthesised logic needs wide zero-detect at high clock rates, such as flag generation and bus-idle detection.

## Interface
- `WIDTH`, 9: input bits per channel; must be ≥1.
- `CHANNELS`, 2: independent reduction channels; must be ≥1.
- `CLK`  in  1  rising-edge clock.
- `R`  in  1  reset; asynchronous, active-low.
- `A`  in  CHANNELS*WIDTH  input vectors; channel c occupies bits [c*WIDTH +: WIDTH].
- `in_valid`  in  1  `A` is valid this cycle.
- `in_ready`  out  1  block accepts `A` this cycle.
- `Y`  out  CHANNELS  per-channel NOR of its `WIDTH` input bits.
- `out_valid`  out  1  `Y` is valid.
- `out_ready`  in  1  downstream accepts `Y`.

## Operation
- Tree fan-in is fixed at 3.
- STAGES = max(1, ceil(log3(WIDTH))). Examples: WIDTH 1→1, 3→1, 4→2, 9→2, 10→3, 27→3.
- Inner stages OR-reduce groups of 3. Incomplete groups are padded with 0, the OR identity.
- The final stage registers the inverted OR, so `Y` is a true NOR.
- Each stage holds a data register per channel plus one shared valid bit.
- Pipeline advance is global: `adv = !out_valid || out_ready`. When `adv` = 0, all stages hold.
- `in_ready = adv`. A transfer occurs when `in_valid && in_ready`.
- When `adv` = 1:
  - stage 0 valid loads `in_valid`;
  - stage k valid loads stage k-1 valid;
  - data regs load even when the valid bit is 0.
- Edge cases:
  - WIDTH=1: single stage, `Y = ~A`.
  - Bubbles: the valid bit propagates 0 and `Y` is not meaningful.
- Channels never interact; handshake signals are shared.

## Timing
- Reset (`R`=0, asynchronous): all valid bits 0, all data regs 0, `Y`=0, `out_valid`=0. `in_ready`=1 combinationally, since `out_valid`=0.
- Reset mid-flight discards all in-flight data. No output is produced for items accepted before reset.
- Latency: a vector accepted at edge n appears with `out_valid`=1 after edge n+STAGES-1, i.e. STAGES cycles from acceptance.
- Throughput: one vector per cycle while `out_ready`=1.
- Stall: with `out_valid`=1 and `out_ready`=0, `Y` and `out_valid` are held stable and `in_ready`=0.
- Simultaneous `out_ready`=1 and `in_valid`=1 on a full pipe: output is consumed and input accepted in the same cycle.
- No combinational path from `A` to `Y`. `in_ready` depends combinationally on `out_ready`.

## Configuration
- `NOR_TREE_PIPE_STICKY_EN`
  - Defined: adds input `sticky_clr` (1 bit) and output `sticky` (CHANNELS bits).
  - `sticky[c]` sets on any output transfer (`out_valid && out_ready`) with `Y[c]`=1.
  - `sticky_clr` clears it synchronously. Simultaneous set and clear: set wins.
  - `sticky` resets to 0.
  - Undefined: the ports and logic are absent; all other behaviour is identical.

## Structure
- Package `nor_tree_pkg`: constant `NOR_TREE_FANIN = 3`, function `clog3(int)` returning the stage count.
- Sub-module `nor_tree_stage`: one registered reduction level, parameterised by input width and an invert flag (set on the last stage only). It is instantiated STAGES times via generate.

## Test plan
- Reset: assert `R`=0 mid-stream, release → `Y`=0, `out_valid`=0, `in_ready`=1; no stale outputs afterwards.
- WIDTH=9, CHANNELS=2, `out_ready`=1:
  - drive ch0=9'h000 and ch1=9'h100 → 2 cycles later `Y`=2'b01, `out_valid`=1;
  - drive back-to-back 9'h000 / 9'h001 → `Y[0]`=1 then 0 on consecutive cycles.
- Backpressure: hold `out_ready`=0 for 5 cycles with a full pipe → `Y` stable, `in_ready`=0. Release → all items drain in order, none lost or duplicated.
- Width sweep WIDTH=1,3,4,10,27: random vectors against a reference model → `out_valid` latency equals 1,1,2,3,3 and `Y` matches NOR.
- With `NOR_TREE_PIPE_STICKY_EN`: one transfer with ch1 all-zero → `sticky`=2'b10. Pulse `sticky_clr` → 2'b00. Clear coinciding with a new hit → `sticky` stays set.

Source files
------------

// File: rtl/nor_tree_pipe_pkg.sv
// nor_tree_pipe_pkg: shared fan-in constant and tree sizing helpers for nor_tree_pipe
package nor_tree_pkg;
    localparam int NOR_TREE_FANIN = 3;

    function automatic int clog3(input int n);
        int s;
        int w;
        s = 1;
        w = NOR_TREE_FANIN;
        while (w < n) begin
            w = w * NOR_TREE_FANIN;
            s = s + 1;
        end
        return s;
    endfunction

    function automatic int stage_width(input int n, input int k);
        int w;
        w = n;
        for (int i = 0; i < k; i++) w = (w + NOR_TREE_FANIN - 1) / NOR_TREE_FANIN;
        return w;
    endfunction
endpackage

// File: rtl/nor_tree_pipe_if.sv
// nor_tree_pipe_if: valid/ready bus of nor_tree_pipe; sticky signals exist only with NOR_TREE_PIPE_STICKY_EN
interface nor_tree_pipe_if #(
    parameter int WIDTH    = 9,
    parameter int CHANNELS = 2
);
    logic [CHANNELS*WIDTH-1:0] A;
    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS-1:0]       Y;
    logic                      out_valid;
    logic                      out_ready;
`ifdef NOR_TREE_PIPE_STICKY_EN
    logic                      sticky_clr;
    logic [CHANNELS-1:0]       sticky;
    modport master (output A, in_valid, out_ready, sticky_clr, input in_ready, Y, out_valid, sticky);
    modport slave  (input A, in_valid, out_ready, sticky_clr, output in_ready, Y, out_valid, sticky);
`else
    modport master (output A, in_valid, out_ready, input in_ready, Y, out_valid);
    modport slave  (input A, in_valid, out_ready, output in_ready, Y, out_valid);
`endif
endinterface

// File: rtl/nor_tree_stage.sv
// nor_tree_stage: one registered 3:1 OR-reduction level per channel, inverting on the last level
module nor_tree_stage
    import nor_tree_pkg::*;
#(
    parameter int  IN_W     = 9,
    parameter int  CHANNELS = 2,
    parameter bit  INV      = 1'b0,
    localparam int OUT_W    = (IN_W + NOR_TREE_FANIN - 1) / NOR_TREE_FANIN
) (
    input  logic                      CLK,
    input  logic                      R,
    input  logic                      adv,
    input  logic                      v_in,
    input  logic [CHANNELS*IN_W-1:0]  d_in,
    output logic                      v_out,
    output logic [CHANNELS*OUT_W-1:0] d_out
);
    logic [CHANNELS*OUT_W-1:0] red;

    // OR each group of three bits; a short last group behaves as if zero-padded
    always_comb begin
        red = '0;
        for (int c = 0; c < CHANNELS; c++)
            for (int j = 0; j < IN_W; j++)
                red[c*OUT_W + j/NOR_TREE_FANIN] = red[c*OUT_W + j/NOR_TREE_FANIN] | d_in[c*IN_W + j];
    end

    // Level register: data loads on every advance even for bubbles
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            d_out <= '0;
            v_out <= 1'b0;
        end else if (adv) begin
            d_out <= INV ? ~red : red;
            v_out <= v_in;
        end
    end
endmodule

// File: rtl/nor_tree_pipe.sv
// nor_tree_pipe: pipelined per-channel wide NOR with global-stall valid/ready handshake
// Defining NOR_TREE_PIPE_STICKY_EN adds per-channel sticky hit flags with a sync clear.
module nor_tree_pipe
    import nor_tree_pkg::*;
#(
    parameter int WIDTH    = 9,
    parameter int CHANNELS = 2
) (
    input  logic           CLK,
    input  logic           R,
    nor_tree_pipe_if.slave bus
);
    localparam int STAGES = clog3(WIDTH);

    logic adv;
    assign adv = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int IW = stage_width(WIDTH, k);
        localparam int OW = stage_width(WIDTH, k + 1);
        logic [CHANNELS*IW-1:0] d;
        logic                   vi;
        logic [CHANNELS*OW-1:0] q;
        logic                   v;
        if (k == 0) begin : g_head
            assign d  = bus.A;
            assign vi = bus.in_valid;
        end else begin : g_link
            assign d  = g_stg[k-1].q;
            assign vi = g_stg[k-1].v;
        end
        nor_tree_stage #(
            .IN_W    (IW),
            .CHANNELS(CHANNELS),
            .INV     (k == STAGES - 1)
        ) u_stage (
            .CLK  (CLK),
            .R    (R),
            .adv  (adv),
            .v_in (vi),
            .d_in (d),
            .v_out(v),
            .d_out(q)
        );
    end

    assign bus.Y         = g_stg[STAGES-1].q;
    assign bus.out_valid = g_stg[STAGES-1].v;

`ifdef NOR_TREE_PIPE_STICKY_EN
    logic [CHANNELS-1:0] sticky;

    // Sticky flags: a delivered Y=1 sets its bit, clear drops it, set beats clear
    always_ff @(posedge CLK or negedge R) begin
        if (!R) sticky <= '0;
        else sticky <= (sticky & ~{CHANNELS{bus.sticky_clr}}) | (bus.Y & {CHANNELS{bus.out_valid && bus.out_ready}});
    end

    assign bus.sticky = sticky;
`endif
endmodule

// File: tb/tb_nor_tree_pipe.sv
// tb_nor_tree_pipe: directed and random checks of nor_tree_pipe against a tick-stamped queue model
module tb_nor_tree_pipe;
    localparam int CH   = 2;
    localparam int NCFG = 6;

    logic CLK = 1'b0;
    logic R = 1'b0;
    int checks = 0;
    int fails = 0;
    int done_cnt = 0;

    always #5 CLK = ~CLK;

    function automatic int wtab(input int i);
        return i == 0 ? 9 : i == 1 ? 1 : i == 2 ? 3 : i == 3 ? 4 : i == 4 ? 10 : 27;
    endfunction

    function automatic int ltab(input int i);
        return i == 0 ? 2 : i == 1 ? 1 : i == 2 ? 1 : i == 3 ? 2 : 3;
    endfunction

    task automatic chk(input string nm, input int w, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (WIDTH=%0d): got %0h, expected %0h", nm, w, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int W  = wtab(g);
        localparam int ST = ltab(g);

        nor_tree_pipe_if #(.WIDTH(W), .CHANNELS(CH)) bus ();
        nor_tree_pipe #(.WIDTH(W), .CHANNELS(CH)) dut (.CLK(CLK), .R(R), .bus(bus));

        logic [CH-1:0] q_y [$];
        int            q_t [$];
        int            tck = 0;
        int            n_pop = 0;
        logic [CH-1:0] stk = '0;
        logic          ev;
        logic          adv;
        logic [CH-1:0] ny;
        logic [63:0]   av;

        function automatic logic [CH*W-1:0] rnd_vec();
            logic [63:0] v;
            logic [63:0] x;
            int m;
            v = '0;
            for (int c = 0; c < CH; c++) begin
                m = $urandom_range(0, 2);
                x = {$urandom, $urandom};
                if (m == 1) x = 64'd1 << $urandom_range(0, W - 1);
                if (m == 0) x = '0;
                v |= (x & ((64'd1 << W) - 1)) << (c * W);
            end
            return v[CH*W-1:0];
        endfunction

        // Model: an item accepted on advance tick t is due at the output once t+ST-1 ticks have elapsed
        always @(negedge CLK) begin
            if (!R) begin
                q_y.delete();
                q_t.delete();
                stk = '0;
                chk("reset_out_valid", W, bus.out_valid, 0);
                chk("reset_y", W, bus.Y, 0);
                chk("reset_in_ready", W, bus.in_ready, 1);
`ifdef NOR_TREE_PIPE_STICKY_EN
                chk("reset_sticky", W, bus.sticky, 0);
`endif
            end else begin
                ev = q_y.size() > 0 && q_t[0] + ST - 1 <= tck;
                chk("out_valid", W, bus.out_valid, ev);
                if (ev) chk("y", W, bus.Y, q_y[0]);
                adv = !ev || bus.out_ready;
                chk("in_ready", W, bus.in_ready, adv);
`ifdef NOR_TREE_PIPE_STICKY_EN
                chk("sticky", W, bus.sticky, stk);
                stk = (stk & ~{CH{bus.sticky_clr}}) | ((ev && bus.out_ready) ? q_y[0] : '0);
`endif
                if (ev && bus.out_ready) begin
                    void'(q_y.pop_front());
                    void'(q_t.pop_front());
                    n_pop++;
                end
                if (adv) tck++;
                if (adv && bus.in_valid) begin
                    av = 64'(bus.A);
                    for (int c = 0; c < CH; c++) ny[c] = ((av >> (c * W)) & ((64'd1 << W) - 1)) == 64'd0;
                    q_y.push_back(ny);
                    q_t.push_back(tck);
                end
            end
        end

        if (g == 0) begin : g_dir
            initial begin
                int p0;
                bus.A = '0;
                bus.in_valid = 1'b0;
                bus.out_ready = 1'b1;
`ifdef NOR_TREE_PIPE_STICKY_EN
                bus.sticky_clr = 1'b0;
`endif
                repeat (3) tick();
                R = 1'b1;
                tick();
                bus.A = {9'h100, 9'h000};
                bus.in_valid = 1'b1;
                tick();
                bus.in_valid = 1'b0;
                tick();
                chk("pin_y_01", W, bus.Y, 2'b01);
                chk("pin_valid_01", W, bus.out_valid, 1);
                bus.A = {9'h000, 9'h000};
                bus.in_valid = 1'b1;
                tick();
                bus.A = {9'h000, 9'h001};
                tick();
                chk("pin_b2b_first", W, bus.Y, 2'b11);
                bus.in_valid = 1'b0;
                tick();
                chk("pin_b2b_second", W, bus.Y, 2'b10);
                tick();
                bus.out_ready = 1'b0;
                bus.in_valid = 1'b1;
                repeat (3) begin
                    bus.A = rnd_vec();
                    tick();
                end
                for (int i = 0; i < 5; i++) begin
                    chk("stall_in_ready", W, bus.in_ready, 0);
                    chk("stall_out_valid", W, bus.out_valid, 1);
                    bus.A = rnd_vec();
                    tick();
                end
                p0 = n_pop;
                bus.in_valid = 1'b0;
                bus.out_ready = 1'b1;
                repeat (3) tick();
                chk("drain_count", W, n_pop - p0, 2);
                chk("drain_empty", W, bus.out_valid, 0);
`ifdef NOR_TREE_PIPE_STICKY_EN
                bus.sticky_clr = 1'b1;
                tick();
                bus.sticky_clr = 1'b0;
                chk("sticky_init_clear", W, bus.sticky, 2'b00);
                bus.A = {9'h000, 9'h0F0};
                bus.in_valid = 1'b1;
                tick();
                bus.in_valid = 1'b0;
                repeat (2) tick();
                chk("sticky_hit", W, bus.sticky, 2'b10);
                bus.sticky_clr = 1'b1;
                tick();
                bus.sticky_clr = 1'b0;
                chk("sticky_clear", W, bus.sticky, 2'b00);
                bus.in_valid = 1'b1;
                tick();
                bus.in_valid = 1'b0;
                tick();
                bus.sticky_clr = 1'b1;
                tick();
                bus.sticky_clr = 1'b0;
                chk("sticky_set_wins", W, bus.sticky, 2'b10);
`endif
                for (int i = 0; i < 300; i++) begin
                    if (i == 150) begin
                        R = 1'b0;
                        #1;
                        chk("mid_reset_y", W, bus.Y, 0);
                        chk("mid_reset_out_valid", W, bus.out_valid, 0);
                        chk("mid_reset_in_ready", W, bus.in_ready, 1);
                        tick();
                        R = 1'b1;
                    end
                    bus.A = rnd_vec();
                    bus.in_valid = $urandom_range(0, 3) != 0;
                    bus.out_ready = $urandom_range(0, 3) != 0;
`ifdef NOR_TREE_PIPE_STICKY_EN
                    bus.sticky_clr = $urandom_range(0, 7) == 0;
`endif
                    tick();
                end
                bus.in_valid = 1'b0;
                bus.out_ready = 1'b1;
                repeat (4) tick();
                done_cnt++;
            end
        end else begin : g_rnd
            initial begin
                int lat;
                bus.A = '0;
                bus.in_valid = 1'b0;
                bus.out_ready = 1'b1;
`ifdef NOR_TREE_PIPE_STICKY_EN
                bus.sticky_clr = 1'b0;
`endif
                wait (R === 1'b1);
                tick();
                bus.A = rnd_vec();
                bus.in_valid = 1'b1;
                tick();
                bus.in_valid = 1'b0;
                lat = 1;
                for (int i = 0; i < 10 && !bus.out_valid; i++) begin
                    tick();
                    lat++;
                end
                chk("latency", W, lat, ST);
                for (int i = 0; i < 400; i++) begin
                    bus.A = rnd_vec();
                    bus.in_valid = $urandom_range(0, 3) != 0;
                    bus.out_ready = $urandom_range(0, 3) != 0;
`ifdef NOR_TREE_PIPE_STICKY_EN
                    bus.sticky_clr = $urandom_range(0, 7) == 0;
`endif
                    tick();
                end
                bus.in_valid = 1'b0;
                bus.out_ready = 1'b1;
                repeat (4) tick();
                done_cnt++;
            end
        end
    end

    initial begin
        for (int i = 0; i < 20000 && done_cnt < NCFG; i++) @(posedge CLK);
        chk("all_configs_done", 0, done_cnt, NCFG);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
